// File: rtl/dmi_pkg.sv
// Shared DMI link definitions: request/response layout, op and resp codes,
// register map constants and the responder state encoding.
package dmi_pkg;

    localparam int REQ_W         = 41;
    localparam int RESP_W        = 34;
    localparam int ADDR_W        = 7;
    localparam int OP_W          = 2;
    localparam int DATA_W        = 32;

    localparam int REQ_ADDR_LSB  = 34;
    localparam int REQ_OP_LSB    = 32;
    localparam int REQ_DATA_LSB  = 0;
    localparam int RESP_DATA_LSB = 2;
    localparam int RESP_CODE_LSB = 0;

    localparam logic [OP_W-1:0] DMI_NOP   = 2'd0;
    localparam logic [OP_W-1:0] DMI_READ  = 2'd1;
    localparam logic [OP_W-1:0] DMI_WRITE = 2'd2;

    localparam logic [1:0] DMI_OK   = 2'd0;
    localparam logic [1:0] DMI_FAIL = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 7'h10;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 7'h11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmi_state_e;

endpackage

// File: rtl/dmi_reg_responder.sv
// Debug-module end of the DMI link: accepts one request at a time, performs the
// register access after a fixed latency and holds the response until taken.
module dmi_reg_responder
    import dmi_pkg::*;
#(
    parameter int unsigned NumRegs       = 16,
    parameter int unsigned ProtBase      = 4,
    parameter int unsigned AccessLatency = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REQ_W-1:0]  dmi_req_i,
    input  logic              dmi_req_valid_i,
    output logic              dmi_req_ready_o,
    output logic [RESP_W-1:0] dmi_resp_o,
    output logic              dmi_resp_valid_o,
    input  logic              dmi_resp_ready_i,
    input  logic              jtag_unlock_i,
    input  logic [31:0]       status_i,
    output logic [31:0]       ctrl_o,
    output logic [7:0]        err_cnt_o,
    output dmi_state_e        state_o
);

    // Handshake: a request transfers on an edge where dmi_req_valid_i and
    // dmi_req_ready_o are both high; a response transfers on an edge where
    // dmi_resp_valid_o and dmi_resp_ready_i are both high. Payloads are stable
    // while valid is high and not yet accepted.

    dmi_state_e          state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   data_q;
    logic                unlock_q;
    logic [RESP_W-1:0]   resp_q;
    logic                resp_valid_q;
    logic [31:0]         ctrl_q;
    logic [7:0]          err_cnt_q;
    logic [DATA_W-1:0]   scratch_q [NumRegs];

    logic                scr_hit;
    logic                scr_prot;
    logic [3:0]          scr_idx;
    logic [DATA_W-1:0]   acc_data;
    logic                acc_fail;
    logic                wr_scr;
    logic                wr_ctrl;

    assign scr_hit  = 32'(addr_q) < NumRegs;
    assign scr_prot = 32'(addr_q) >= ProtBase;
    assign scr_idx  = addr_q[3:0];

    // Access decode works on the latched request and latched unlock state.
    always_comb begin
        acc_data = '0;
        acc_fail = 1'b0;
        wr_scr   = 1'b0;
        wr_ctrl  = 1'b0;
        case (op_q)
            DMI_NOP: ;
            DMI_READ: begin
                if (scr_hit)                    acc_data = scratch_q[scr_idx];
                else if (addr_q == ADDR_CTRL)   acc_data = ctrl_q;
                else if (addr_q == ADDR_STATUS) acc_data = status_i;
                else                            acc_fail = 1'b1;
            end
            DMI_WRITE: begin
                if (scr_hit && (!scr_prot || unlock_q)) begin
                    wr_scr   = 1'b1;
                    acc_data = data_q;
                end else if (addr_q == ADDR_CTRL && unlock_q) begin
                    wr_ctrl  = 1'b1;
                    acc_data = data_q;
                end else begin
                    acc_fail = 1'b1;
                end
            end
            default: acc_fail = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            op_q         <= '0;
            data_q       <= '0;
            unlock_q     <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            ctrl_q       <= '0;
            err_cnt_q    <= '0;
            for (int i = 0; i < int'(NumRegs); i++) scratch_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dmi_req_valid_i) begin
                        addr_q   <= dmi_req_i[REQ_ADDR_LSB +: ADDR_W];
                        op_q     <= dmi_req_i[REQ_OP_LSB +: OP_W];
                        data_q   <= dmi_req_i[REQ_DATA_LSB +: DATA_W];
                        unlock_q <= jtag_unlock_i;
                        cnt_q    <= 4'(AccessLatency - 1);
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        resp_q[RESP_DATA_LSB +: DATA_W] <= acc_data;
                        resp_q[RESP_CODE_LSB +: 2]      <= acc_fail ? DMI_FAIL : DMI_OK;
                        resp_valid_q <= 1'b1;
                        if (wr_scr)  scratch_q[scr_idx] <= data_q;
                        if (wr_ctrl) ctrl_q <= data_q;
                        if (acc_fail && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (dmi_resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Ready is held low for the whole time reset is asserted.
    assign dmi_req_ready_o  = (state_q == ST_IDLE) && rst_ni;
    assign dmi_resp_o       = resp_q;
    assign dmi_resp_valid_o = resp_valid_q;
    assign ctrl_o           = ctrl_q;
    assign err_cnt_o        = err_cnt_q;
    assign state_o          = state_q;

endmodule

// File: doc/dmi_reg_responder.md
Name: dmi_reg_responder

Overview:
- Responder (debug-module end) of the DMI request/response link driven by the JTAG DTM.
- Accepts 41-bit DMI requests over valid/ready, performs reads and writes on a small debug register file, and returns 34-bit responses over valid/ready.
- Enforces the JTAG unlock: protected registers are writable only while jtag_unlock_i is high.
- Sits in the core clock domain, directly behind the DMI clock-domain crossing.

Parameters:
- NumRegs, 16: number of general 32-bit scratch registers, at addresses 0 to NumRegs-1 (max 16).
- ProtBase, 4: scratch addresses at or above ProtBase are protected.
- AccessLatency, 2: clock edges from request accept to response valid; legal range 1 to 15.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- dmi_req_i  in  41  addr[40:34], op[33:32], data[31:0]
- dmi_req_valid_i  in  1  request valid
- dmi_req_ready_o  out  1  request ready
- dmi_resp_o  out  34  data[33:2], resp[1:0]
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  response ready
- jtag_unlock_i  in  1  unlock status from the HMAC check
- status_i  in  32  read-only status word, mapped at 0x11
- ctrl_o  out  32  control register, mapped at 0x10 (read/write, protected)
- err_cnt_o  out  8  saturating count of failed responses

Behaviour:
- Reset values: dmi_req_ready_o=0 while rst_ni is low, then 1 (IDLE). dmi_resp_valid_o=0, dmi_resp_o=0, ctrl_o=0, err_cnt_o=0, all scratch registers 0. Reset mid-operation aborts the access: no write commits, no response is issued.
- Op encoding: 0 nop, 1 read, 2 write, 3 reserved.
- Resp encoding: 0 success, 2 failed.
- State machine:
  - IDLE: dmi_req_ready_o=1. When dmi_req_valid_i is high, latch addr, op, data and jtag_unlock_i; load the counter with AccessLatency-1; go to WAIT.
  - WAIT: dmi_req_ready_o=0. Decrement the counter. When the counter is 0, perform the access, register the response, set dmi_resp_valid_o, go to RESP. Result: response valid exactly AccessLatency edges after the accepting edge.
  - RESP: hold dmi_resp_o and dmi_resp_valid_o stable until dmi_resp_ready_i is high. On that handshake edge, clear valid and go to IDLE. Ready returns one cycle after the handshake. Minimum request period is AccessLatency+2 cycles.
- Access rules (unlock means the latched copy; a lock change during WAIT is ignored):
  - Nop: resp 0, data 0.
  - Reserved op: resp 2, data 0.
  - Read scratch or 0x10: resp 0 with the register value; allowed even when locked.
  - Read 0x11: resp 0 with status_i sampled at the response edge.
  - Write scratch below ProtBase: always succeeds, resp 0, data echoes the written value.
  - Write scratch at or above ProtBase, or 0x10: succeeds only when unlocked. When locked: resp 2, data 0, register unchanged.
  - Write 0x11: resp 2, no effect.
  - Any unmapped address: resp 2, data 0, no effect.
- Write commits on the same edge that raises dmi_resp_valid_o.
- err_cnt_o increments on each edge that issues a resp-2 response and saturates at 255.
- dmi_req_valid_i while not ready is ignored; the request is held upstream.

Decomposition:
- Shared package dmi_pkg holds:
  - the request/response field offsets;
  - op constants DMI_NOP, DMI_READ, DMI_WRITE;
  - resp constants DMI_OK, DMI_FAIL;
  - address constants ADDR_CTRL=7'h10, ADDR_STATUS=7'h11;
  - the state enum.
- No sub-module. The register file and decode stay inline.

Test Plan:
- Write 0x2 data 0xDEADBEEF with op 2, then read 0x2 with op 1. Each response asserts valid 2 cycles after its accept; the write response is resp 0 with data 0xDEADBEEF, and the read returns resp 0 with data 0xDEADBEEF.
- With jtag_unlock_i=0, write 0x10 data 0x1. Response is resp 2, data 0; ctrl_o stays 0 and err_cnt_o=1. Set unlock and repeat: resp 0 and ctrl_o=0x1.
- Accept a write to 0x8 with unlock=1, then drop unlock during WAIT. The write still commits with resp 0.
- Hold dmi_resp_ready_i=0 for 5 cycles. dmi_resp_o stays stable and dmi_req_ready_o stays 0. A second dmi_req_valid_i pulse during the stall is not accepted.
- Read 0x7F (unmapped), then 0x11 with status_i=0xA5A5A5A5. First response is resp 2 with data 0; second is resp 0 with data 0xA5A5A5A5. Issue 256 failing requests: err_cnt_o saturates at 255.
- Pulse rst_ni low during WAIT of a write to 0x1. No response is issued, register 0x1 reads 0, and dmi_req_ready_o=1 after reset releases.
